// File: rtl/guess_round_controller_pkg.sv
// Shared types and constants for the guessing-game round controller.
// The state encoding here is visible on the o_state debug port.
package guess_round_controller_pkg;

  localparam int STATE_W  = 3;
  localparam int ANSWER_W = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE       = 3'd0,
    ST_FETCH      = 3'd1,
    ST_WAIT_DATA  = 3'd2,
    ST_WAIT_GUESS = 3'd3,
    ST_EVAL       = 3'd4,
    ST_SHOW       = 3'd5,
    ST_DONE       = 3'd6
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/guess_round_controller_cycle_timer.sv
// Load/enable down-counter shared by the controller for read latency, result display and guess timeout.
// o_done is high during the enabled cycle in which the count reaches its last tick.
module cycle_timer
  import guess_round_controller_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_done
);

  logic [W-1:0] r_count;

  // Load wins over counting so a phase can reload the timer in its final cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_done = i_en && (r_count == W'(1));

endmodule

// File: rtl/guess_round_controller.sv
// Guessing-game round sequencer: fetches each answer, scores a button-triggered guess, drives LEDs.
// Build option: define GUESS_TIMEOUT_EN to score an unanswered round as wrong after TIMEOUT_CYCLES.
module guess_round_controller
  import guess_round_controller_pkg::*;
#(
  parameter int NUM_ROUNDS     = 10,
  parameter int ADDR_W         = 4,
  parameter int READ_LATENCY   = 1,
  parameter int SHOW_CYCLES    = 50_000_000,
  parameter int SCORE_W        = 4,
  parameter int TIMEOUT_CYCLES = 500_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic                i_btn,
  input  logic [ANSWER_W-1:0] i_sw,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic                o_mem_rd_en,
  input  logic [ANSWER_W-1:0] i_mem_data,
  output logic                o_led_green,
  output logic                o_led_red,
  output logic [SCORE_W-1:0]  o_score,
  output logic [ADDR_W-1:0]   o_round_idx,
  output logic                o_busy,
  output logic                o_game_over,
  output logic [STATE_W-1:0]  o_state
);

`ifdef GUESS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int TMR_MAX = max3(READ_LATENCY, SHOW_CYCLES, TO_EN ? TIMEOUT_CYCLES : 1);
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  state_t              r_state;
  logic                r_btn_last;
  logic [ADDR_W-1:0]   r_round_idx;
  logic [ANSWER_W-1:0] r_answer_q;
  logic [ANSWER_W-1:0] r_guess_q;
  logic                r_led_green;
  logic                r_led_red;
  logic [SCORE_W-1:0]  r_score;
  logic                r_mem_rd_en;
  logic                r_busy;
  logic                r_game_over;
`ifdef GUESS_TIMEOUT_EN
  logic                r_timed_out;
`endif

  logic             w_press;
  logic             w_correct;
  logic             w_last_round;
  logic             w_tmr_load;
  logic [TMR_W-1:0] w_tmr_val;
  logic             w_tmr_en;
  logic             w_tmr_done;

  assign w_press      = i_btn & ~r_btn_last;
  assign w_last_round = (r_round_idx == ADDR_W'(NUM_ROUNDS - 1));
`ifdef GUESS_TIMEOUT_EN
  assign w_correct    = !r_timed_out && (r_guess_q == r_answer_q);
`else
  assign w_correct    = (r_guess_q == r_answer_q);
`endif

  // Read contract: o_mem_rd_en is a one-cycle strobe with no backpressure; i_mem_data is
  // trusted only in the READ_LATENCY-th cycle after the strobe and ignored at all other times.
  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_val  = '0;
    w_tmr_en   = 1'b0;
    case (r_state)
      ST_FETCH: begin
        w_tmr_load = 1'b1;
        w_tmr_val  = TMR_W'(READ_LATENCY);
      end
      ST_WAIT_DATA: begin
        w_tmr_en = 1'b1;
`ifdef GUESS_TIMEOUT_EN
        if (w_tmr_done) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = TMR_W'(TIMEOUT_CYCLES);
        end
`endif
      end
`ifdef GUESS_TIMEOUT_EN
      ST_WAIT_GUESS: w_tmr_en = 1'b1;
`endif
      ST_EVAL: begin
        w_tmr_load = 1'b1;
        w_tmr_val  = TMR_W'(SHOW_CYCLES);
      end
      ST_SHOW: w_tmr_en = 1'b1;
      default: ;
    endcase
  end

  cycle_timer #(
    .W(TMR_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_en       (w_tmr_en),
    .o_done     (w_tmr_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_btn_last  <= 1'b0;
      r_round_idx <= '0;
      r_answer_q  <= '0;
      r_guess_q   <= '0;
      r_led_green <= 1'b0;
      r_led_red   <= 1'b0;
      r_score     <= '0;
      r_mem_rd_en <= 1'b0;
      r_busy      <= 1'b0;
      r_game_over <= 1'b0;
`ifdef GUESS_TIMEOUT_EN
      r_timed_out <= 1'b0;
`endif
    end else begin
      r_btn_last  <= i_btn;
      r_mem_rd_en <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            r_score     <= '0;
            r_round_idx <= '0;
            r_led_green <= 1'b0;
            r_led_red   <= 1'b0;
            r_game_over <= 1'b0;
            r_busy      <= 1'b1;
            r_mem_rd_en <= 1'b1;
            r_state     <= ST_FETCH;
          end
        end
        ST_FETCH: r_state <= ST_WAIT_DATA;
        ST_WAIT_DATA: begin
          if (w_tmr_done) begin
            r_answer_q <= i_mem_data;
            r_state    <= ST_WAIT_GUESS;
          end
        end
        ST_WAIT_GUESS: begin
          // A press on the expiry cycle takes priority over the timeout.
          if (w_press) begin
            r_guess_q <= i_sw;
`ifdef GUESS_TIMEOUT_EN
            r_timed_out <= 1'b0;
`endif
            r_state   <= ST_EVAL;
          end
`ifdef GUESS_TIMEOUT_EN
          else if (w_tmr_done) begin
            r_timed_out <= 1'b1;
            r_state     <= ST_EVAL;
          end
`endif
        end
        ST_EVAL: begin
          if (w_correct) begin
            r_led_green <= 1'b1;
            r_led_red   <= 1'b0;
            if (r_score != '1) begin
              r_score <= r_score + 1'b1;
            end
          end else begin
            r_led_green <= 1'b0;
            r_led_red   <= 1'b1;
          end
          r_state <= ST_SHOW;
        end
        ST_SHOW: begin
          if (w_tmr_done) begin
            if (w_last_round) begin
              r_busy      <= 1'b0;
              r_game_over <= 1'b1;
              r_state     <= ST_DONE;
            end else begin
              r_round_idx <= r_round_idx + 1'b1;
              r_mem_rd_en <= 1'b1;
              r_state     <= ST_FETCH;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_mem_addr  = r_round_idx;
  assign o_round_idx = r_round_idx;
  assign o_mem_rd_en = r_mem_rd_en;
  assign o_led_green = r_led_green;
  assign o_led_red   = r_led_red;
  assign o_score     = r_score;
  assign o_busy      = r_busy;
  assign o_game_over = r_game_over;
  assign o_state     = r_state;

endmodule

// File: tb/tb_guess_round_controller.sv
// Randomized bench for guess_round_controller: plays whole games against a latency-accurate memory
// model and a round-level reference. Honours GUESS_TIMEOUT_EN when the design is built with it.
`timescale 1ns/1ps
module tb_guess_round_controller;

  localparam int NR  = 5;
  localparam int AW  = 3;
  localparam int RL  = 3;
  localparam int SC  = 4;
  localparam int SW_ = 2;
  localparam int TO  = 16;
  localparam int SCORE_MAX = (1 << SW_) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic          i_btn = 1'b0;
  logic [3:0]    i_sw = 4'd0;
  logic [AW-1:0] o_mem_addr;
  logic          o_mem_rd_en;
  logic [3:0]    i_mem_data;
  logic          o_led_green;
  logic          o_led_red;
  logic [SW_-1:0] o_score;
  logic [AW-1:0] o_round_idx;
  logic          o_busy;
  logic          o_game_over;
  logic [2:0]    o_state;

  guess_round_controller #(
    .NUM_ROUNDS     (NR),
    .ADDR_W         (AW),
    .READ_LATENCY   (RL),
    .SHOW_CYCLES    (SC),
    .SCORE_W        (SW_),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (i_start),
    .i_btn       (i_btn),
    .i_sw        (i_sw),
    .o_mem_addr  (o_mem_addr),
    .o_mem_rd_en (o_mem_rd_en),
    .i_mem_data  (i_mem_data),
    .o_led_green (o_led_green),
    .o_led_red   (o_led_red),
    .o_score     (o_score),
    .o_round_idx (o_round_idx),
    .o_busy      (o_busy),
    .o_game_over (o_game_over),
    .o_state     (o_state)
  );

  // ---- clock / reset ----
  always #5 clk = ~clk;

  // ---- scoreboard state ----
  int            n_tests = 0;
  int            n_fail  = 0;
  logic [AW-1:0] exp_q[$];
  logic [3:0]    mem [NR];
  int            m_score;
  logic          m_green;
  logic          m_red;
  bit            aborted;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---- answer memory: data valid only in the RL-th cycle after the strobe, junk otherwise ----
  int            pend_cnt = -1;
  logic [AW-1:0] pend_addr = '0;
  always @(negedge clk) begin
    if (o_mem_rd_en === 1'b1) begin
      if (exp_q.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
      else check("rd_addr_seq", o_mem_addr, exp_q.pop_front());
    end
    if (pend_cnt >= 0) pend_cnt++;
    if (o_mem_rd_en === 1'b1) begin
      pend_cnt  = 0;
      pend_addr = o_mem_addr;
    end
    if (pend_cnt == RL) begin
      i_mem_data = mem[pend_addr];
      pend_cnt   = -1;
    end else begin
      i_mem_data = mem[pend_addr] ^ 4'($urandom_range(1, 15));
    end
  end

  // ---- driver: one round, entered just after the edge that starts FETCH ----
  task automatic play_round(input int r, input int guess_mode, input bit do_reset);
    logic [3:0] guess;
    bit         correct;
    bit         exp_correct;
    int         mode;
    int         w;
    check("fetch_rd_en", o_mem_rd_en, 1);
    check("fetch_addr", o_mem_addr, r);
    check("round_idx", o_round_idx, r);
    check("busy", o_busy, 1);
    tick();
    check("rd_one_cycle", o_mem_rd_en, 0);
    check("st_wait_data", o_state, 2);
    if (do_reset) begin
      #2 rst_n = 1'b0;
      #1;
      check("arst_outputs", {o_mem_rd_en, o_busy, o_led_green, o_led_red, o_game_over,
                             o_score, o_mem_addr, o_round_idx}, 0);
      check("arst_state", o_state, 0);
      tick();
      tick();
      rst_n = 1'b1;
      repeat (6) tick();
      check("post_rst_idle", o_state, 0);
      check("post_rst_quiet", {o_busy, o_score, o_led_green, o_led_red}, 0);
      exp_q.delete();
      aborted = 1'b1;
      return;
    end
    if ($urandom_range(0, 2) == 0) i_btn = 1'b1;
    repeat (RL) tick();
    check("st_wait_guess", o_state, 3);

    case (guess_mode)
      1: correct = 1'b1;
      2: correct = 1'b0;
      default: correct = 1'($urandom_range(0, 1));
    endcase
    guess = correct ? mem[r] : (mem[r] ^ 4'($urandom_range(1, 15)));
    mode  = $urandom_range(0, 3);

`ifdef GUESS_TIMEOUT_EN
    if (mode >= 2) begin
      i_btn = 1'b0;
      i_sw  = (mode == 2) ? mem[r] : guess;
      repeat (TO - 1) begin
        tick();
        check("wg_before_expiry", o_state, 3);
      end
      if (mode == 3) i_btn = 1'b1;
      tick();
      exp_correct = (mode == 3) && correct;
    end else
`endif
    begin
      w = (mode >= 2) ? 20 : $urandom_range(0, 3);
      repeat (w) begin
        tick();
        check("wg_waiting", o_state, 3);
      end
      check("wg_leds_hold", {o_led_green, o_led_red}, {m_green, m_red});
      if (i_btn) begin
        i_btn = 1'b0;
        tick();
        check("wg_release", o_state, 3);
      end
      i_sw  = guess;
      i_btn = 1'b1;
      tick();
      exp_correct = correct;
    end
    check("st_eval", o_state, 4);
    i_sw  = 4'($urandom_range(0, 15));
    i_btn = 1'($urandom_range(0, 1));
    if (exp_correct) begin
      m_green = 1'b1;
      m_red   = 1'b0;
      m_score = (m_score + 1 > SCORE_MAX) ? SCORE_MAX : m_score + 1;
    end else begin
      m_green = 1'b0;
      m_red   = 1'b1;
    end
    tick();
    check("leds", {o_led_green, o_led_red}, {m_green, m_red});
    check("score", o_score, m_score);
    repeat (SC - 1) begin
      i_btn = 1'($urandom_range(0, 1));
      tick();
      check("show_no_fetch", o_mem_rd_en, 0);
      check("show_hold", {o_state, o_led_green, o_led_red, o_score}, {3'd5, m_green, m_red, 2'(m_score)});
    end
    tick();
    if (r == NR - 1) begin
      check("done_state", o_state, 6);
      check("done_flags", {o_game_over, o_busy}, 2'b10);
    end
  endtask

  task automatic play_game(input int guess_mode, input int reset_round, input bit simul_press);
    foreach (mem[a]) mem[a] = 4'($urandom_range(0, 15));
    for (int a = 0; a < NR; a++) exp_q.push_back(AW'(a));
    aborted = 1'b0;
    i_start = 1'b1;
    if (simul_press) i_btn = 1'b1;
    tick();
    i_start = 1'b0;
    m_score = 0;
    m_green = 1'b0;
    m_red   = 1'b0;
    check("start_clear", {o_led_green, o_led_red, o_game_over, o_score}, 0);
    check("st_fetch", o_state, 1);
    for (int r = 0; r < NR; r++) begin
      play_round(r, guess_mode, r == reset_round);
      if (aborted) return;
    end
    check("game_score", o_score, m_score);
    check("addr_seq_len", exp_q.size(), 0);
  endtask

  // ---- main sequence ----
  initial begin
    repeat (3) tick();
    check("rst_outputs", {o_mem_rd_en, o_busy, o_led_green, o_led_red, o_game_over,
                          o_score, o_mem_addr, o_round_idx}, 0);
    check("rst_state", o_state, 0);
    rst_n = 1'b1;
    repeat (4) begin
      i_btn = ~i_btn;
      tick();
      check("idle_no_start", {o_state, o_busy}, 0);
    end
    i_btn = 1'b0;
    tick();

    play_game(1, -1, 1'b1);
    check("sat_score", o_score, SCORE_MAX);
    repeat (6) begin
      i_btn = ~i_btn;
      tick();
      check("done_ignores_btn", {o_state, o_score, o_led_green, o_led_red},
            {3'd6, 2'(SCORE_MAX), 1'b1, 1'b0});
    end

    play_game(2, -1, 1'b0);
    check("all_wrong_score", o_score, 0);
    play_game(0, 2, 1'b0);
    repeat (4) play_game(0, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
